centroid_feeder: RTL
====================

Name: centroid_feeder

Overview:
- Producer/consumer for the other end of the gravity_center point-stream interface.
- Holds a host-loaded list of DEPTH weighted points (X, Y, W) and, on start, streams them one per clock into gravity_center.
- Waits the fixed result latency, then captures Xc/Yc into result registers with a one-cycle valid pulse.
- Sits between the host/register interface and gravity_center.

Parameters:
- DEPTH, 5, number of points per frame; must equal the gravity_center window size.
- CAP_LAT, 2, cycles from the clock edge writing the last sample to the edge capturing Xc/Yc.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  load strobe for the point buffer.
- wr_addr  input  3  buffer index, 0..DEPTH-1.
- wr_x  input  8  point X.
- wr_y  input  8  point Y.
- wr_w  input  4  point weight.
- start  input  1  one-cycle request to stream the buffer.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse, coincident with result capture.
- res_x  output  8  captured Xc.
- res_y  output  8  captured Yc.
- res_err  output  1  set if ready was low at capture; sticky until next accepted start.
- X  output  8  sample X to gravity_center.
- Y  output  8  sample Y to gravity_center.
- W  output  4  sample W to gravity_center.
- ready  input  1  gravity_center ready.
- Xc  input  8  gravity_center X centre.
- Yc  input  8  gravity_center Y centre.

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy=0, done=0, res_x=0, res_y=0, res_err=0, X=Y=0, W=0; all buffer weights cleared to 0, buffer X/Y cleared to 0. Reset mid-stream aborts immediately with no done pulse.
- Buffer load:
  - Write on wr_en in IDLE only; ignored when busy.
  - wr_addr >= DEPTH ignored.
  - wr_en together with accepted start: the write lands, and the stream uses the old contents for that index only if it is already emitted (index 0 is emitted first, so it always reads the pre-write value).
- States: IDLE -> STREAM -> WAIT -> CAPTURE -> IDLE.
- IDLE:
  - X/Y/W driven 0, so gravity_center sees zero-weight samples.
  - start accepted: idx<=0, res_err<=0, busy<=1, go to STREAM.
- STREAM:
  - Registered outputs: X/Y/W = buf[idx] on the edge entering or remaining in STREAM.
  - Exactly DEPTH consecutive samples, indices 0..DEPTH-1, one per cycle, no gaps.
  - After the last sample, W returns to 0 on the next edge.
- WAIT: counts CAP_LAT-1 cycles after the last sample edge.
- CAPTURE edge: res_x<=Xc, res_y<=Yc, done<=1 for one cycle, res_err<=~ready, busy<=0, back to IDLE.
- Latency: start accepted at edge e0; samples on edges e1..eDEPTH; capture at edge eDEPTH+CAP_LAT (e7 with defaults); done is high during the following cycle.
- start while busy is ignored, with no queuing.
- start during the done cycle is accepted, giving back-to-back frames.
- DEPTH consecutive samples overwrite the whole gravity_center window regardless of its internal counter phase, so no alignment is needed.
- Zero total weight: gravity_center returns 0; captured as-is, not an error.

Decomposition:
- Shared package holds the constants PT_W=8, WT_W=4, DEPTH=5, CAP_LAT=2, plus the FSM state encoding typedef (IDLE, STREAM, WAIT, CAPTURE).
- One natural sub-module: centroid_feeder_buf. It is the DEPTH-entry point register file with one write port, one read port, and clear on reset.

Test Plan:
- Load x=0,10,20,30,40; y=100 for all; w=1 for all; start -> done at e7+1 cycle; res_x=20, res_y=100, res_err=0.
- Load x0=0 w0=3, x1=255 w1=1, rest w=0, y=0 -> res_x=64 (rounded (255+2)/4), res_y=0.
- All weights 0, start -> res_x=0, res_y=0, done pulses, res_err=0.
- Start, then pulse start again at e2 and wr_en at e3 -> the second start is ignored; the buffer is unchanged; exactly one done; the W sequence matches the original buffer.
- Assert rst at e3 mid-stream -> next cycle busy=0, W=0, res_x=res_y=0, no done; a fresh start completes normally.
- Start asserted in the done cycle -> second frame streams immediately; two done pulses exactly 8 cycles apart (DEPTH+CAP_LAT+1); res_x/res_y are identical for both frames.

Source files
------------

// File: rtl/centroid_feeder_pkg.sv
// Shared constants, point record and FSM encoding for the centroid feeder.
// The feeder streams a host-loaded point list into gravity_center and captures its result.
package centroid_feeder_pkg;

  localparam int PT_W    = 8;
  localparam int WT_W    = 4;
  localparam int DEPTH   = 5;
  localparam int CAP_LAT = 2;
  localparam int AW      = 3;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [PT_W-1:0] x;
    logic [PT_W-1:0] y;
    logic [WT_W-1:0] w;
  } point_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    CAPTURE
  } state_t;

endpackage

// File: rtl/centroid_feeder_buf.sv
// DEPTH-entry point register file: one write port, one registered read port.
// All entries clear on reset so an unloaded slot streams as a zero-weight point.
module centroid_feeder_buf
  import centroid_feeder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  point_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output point_t        rd_data
);

  point_t mem [DEPTH];
  point_t rd_data_reg;

  // Read and write share an edge; the read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data_reg <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/centroid_feeder.sv
// Streams the point buffer into gravity_center on start, waits the result latency,
// then captures Xc/Yc with a one-cycle done pulse.
module centroid_feeder
  import centroid_feeder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [PT_W-1:0] wr_x,
  input  logic [PT_W-1:0] wr_y,
  input  logic [WT_W-1:0] wr_w,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [PT_W-1:0] res_x,
  output logic [PT_W-1:0] res_y,
  output logic            res_err,
  output logic [PT_W-1:0] X,
  output logic [PT_W-1:0] Y,
  output logic [WT_W-1:0] W,
  input  logic            ready,
  input  logic [PT_W-1:0] Xc,
  input  logic [PT_W-1:0] Yc
);

  state_t           state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic [CNT_W-1:0] wait_reg, wait_next;
  logic             busy_reg, done_reg, res_err_reg;
  logic [PT_W-1:0]  res_x_reg, res_y_reg;
  point_t           sample_reg;
  point_t           rd_data;
  point_t           wr_data;
  logic             wr_ok;
  logic             last_idx;

  assign wr_ok    = wr_en && (state_reg == IDLE) && (wr_addr < AW'(DEPTH));
  assign wr_data  = '{x: wr_x, y: wr_y, w: wr_w};
  assign last_idx = (idx_reg == AW'(DEPTH - 1));

  // Read address runs one step ahead so buf[idx] is already registered when emitted.
  centroid_feeder_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_next),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        idx_next = '0;
        if (start) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (last_idx) begin
          idx_next   = '0;
          wait_next  = '0;
          state_next = (CAP_LAT > 1) ? WAIT : CAPTURE;
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end
      WAIT: begin
        if (wait_reg == CNT_W'(CAP_LAT - 2)) begin
          state_next = CAPTURE;
        end else begin
          wait_next = wait_reg + CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      wait_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      res_x_reg   <= '0;
      res_y_reg   <= '0;
      res_err_reg <= 1'b0;
      sample_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      wait_reg  <= wait_next;
      done_reg  <= 1'b0;
      // Outside STREAM gravity_center only ever sees zero-weight samples.
      sample_reg <= (state_reg == STREAM) ? rd_data : '0;
      if (state_reg == IDLE && start) begin
        busy_reg    <= 1'b1;
        res_err_reg <= 1'b0;
      end
      if (state_reg == CAPTURE) begin
        res_x_reg   <= Xc;
        res_y_reg   <= Yc;
        res_err_reg <= ~ready;
        done_reg    <= 1'b1;
        busy_reg    <= 1'b0;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign res_x   = res_x_reg;
  assign res_y   = res_y_reg;
  assign res_err = res_err_reg;
  assign X       = sample_reg.x;
  assign Y       = sample_reg.y;
  assign W       = sample_reg.w;

endmodule
